// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path: rx FSM states and
// bit-timing calculations used by uart_rx_fifo.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  function automatic int calc_cpb(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  // Bit counter is never narrower than 11 bits so slow baud rates still fit.
  function automatic int cnt_width(input int cpb);
    int w;
    w = $clog2(cpb) + 1;
    return (w < 11) ? 11 : w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; head data reads as zero when empty.
// A push and a pop in the same cycle both take effect, even when full.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver feeding a FWFT FIFO with sticky overflow/framing flags.
// Define UART_RX_ECHO_EN to retransmit every received byte on TX.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CLK_HZ = 12000000,
  parameter int BAUD   = 9600,
  parameter int DEPTH  = 16
) (
  input  logic                     iCE_CLK,
  input  logic                     RST_N,
  input  logic                     RX,
  input  logic                     POP,
  input  logic                     CLR_ERR,
  output logic [DATA_W-1:0]        REC_BYTE,
  output logic                     VALID,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     OVERFLOW,
  output logic                     FRAME_ERR,
  output logic                     TX
);

  localparam int CPB   = calc_cpb(CLK_HZ, BAUD);
  localparam int CNT_W = cnt_width(CPB);
  localparam logic [CNT_W-1:0] CPB_LAST  = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CPB / 2 - 1);
  localparam logic [3:0]       LAST_BIT  = 4'(DATA_W - 1);

  logic              rx_meta;
  logic              rx_s;
  rx_state_t         state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [3:0]        bit_idx, bit_d;
  logic [DATA_W-1:0] rx_shift, shift_d;
  logic              push_d;
  logic              rx_push;
  logic              ferr_set;
  logic              ovf_set;
  logic              fifo_full;
  logic              fifo_empty;

  always_ff @(posedge iCE_CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge iCE_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      rx_shift <= '0;
      rx_push  <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      bit_idx  <= bit_d;
      rx_shift <= shift_d;
      rx_push  <= push_d;
    end
  end

  // Start bit is re-checked at mid-bit so short low glitches are rejected.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt + 1'b1;
    bit_d    = bit_idx;
    shift_d  = rx_shift;
    push_d   = 1'b0;
    ferr_set = 1'b0;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == CPB_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, rx_shift[DATA_W-1:1]};
          bit_d   = bit_idx + 4'd1;
          if (bit_idx == LAST_BIT) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt == CPB_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            push_d  = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  sync_fifo #(
    .WIDTH(DATA_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (iCE_CLK),
    .rst_n (RST_N),
    .push  (rx_push),
    .pop   (POP),
    .wdata (rx_shift),
    .rdata (REC_BYTE),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (COUNT)
  );

  assign VALID   = !fifo_empty;
  assign ovf_set = rx_push && fifo_full && !POP;

  // A flag being set wins over a simultaneous clear request.
  always_ff @(posedge iCE_CLK or negedge RST_N) begin
    if (!RST_N) begin
      OVERFLOW  <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      if (ovf_set)      OVERFLOW <= 1'b1;
      else if (CLR_ERR) OVERFLOW <= 1'b0;
      if (ferr_set)     FRAME_ERR <= 1'b1;
      else if (CLR_ERR) FRAME_ERR <= 1'b0;
    end
  end

`ifdef UART_RX_ECHO_EN
  logic              hold_valid;
  logic [DATA_W-1:0] hold_data;
  logic              tx_busy;
  logic              tx_load;
  logic [DATA_W+1:0] tx_shift;
  logic [CNT_W-1:0]  tx_cnt;
  logic [3:0]        tx_bits;

  assign tx_load = !tx_busy && hold_valid;
  assign TX      = tx_busy ? tx_shift[0] : 1'b1;

  // Echo bytes wait in a one-entry holding register; if it is still occupied
  // when another byte lands, that byte is simply not echoed.
  always_ff @(posedge iCE_CLK or negedge RST_N) begin
    if (!RST_N) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
      tx_busy    <= 1'b0;
      tx_shift   <= '1;
      tx_cnt     <= '0;
      tx_bits    <= '0;
    end else begin
      if (rx_push && (!hold_valid || tx_load)) begin
        hold_valid <= 1'b1;
        hold_data  <= rx_shift;
      end else if (tx_load) begin
        hold_valid <= 1'b0;
      end
      if (tx_load) begin
        tx_busy  <= 1'b1;
        tx_shift <= {1'b1, hold_data, 1'b0};
        tx_cnt   <= '0;
        tx_bits  <= '0;
      end else if (tx_busy) begin
        if (tx_cnt == CPB_LAST) begin
          tx_cnt   <= '0;
          tx_shift <= {1'b1, tx_shift[DATA_W+1:1]};
          tx_bits  <= tx_bits + 4'd1;
          if (tx_bits == 4'(DATA_W + 1)) tx_busy <= 1'b0;
        end else begin
          tx_cnt <= tx_cnt + 1'b1;
        end
      end
    end
  end
`else
  assign TX = 1'b1;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized scoreboard bench for uart_rx_fifo; runs a fast bit rate (16 clocks
// per bit) and checks TX echo framing when UART_RX_ECHO_EN is defined.
module tb_uart_rx_fifo;

  localparam int CLK_HZ = 160000;
  localparam int BAUD   = 10000;
  localparam int CPB    = CLK_HZ / BAUD;
  localparam int DEPTH  = 16;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              rx;
  logic              pop;
  logic              clr_err;
  logic [DATA_W-1:0] rec_byte;
  logic              valid;
  logic [4:0]        count;
  logic              overflow;
  logic              frame_err;
  logic              tx;

  logic [7:0] exp_q[$];
  bit         exp_ovf;
  bit         exp_ferr;
  int         n_cmp;
  int         n_bad;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .DATA_W(DATA_W),
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD),
    .DEPTH (DEPTH)
  ) dut (
    .iCE_CLK  (clk),
    .RST_N    (rst_n),
    .RX       (rx),
    .POP      (pop),
    .CLR_ERR  (clr_err),
    .REC_BYTE (rec_byte),
    .VALID    (valid),
    .COUNT    (count),
    .OVERFLOW (overflow),
    .FRAME_ERR(frame_err),
    .TX       (tx)
  );

  task automatic checkVal(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends one frame and updates the model once the frame is complete.
  task automatic applyStimulus(input logic [7:0] b, input bit stop_ok);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop_ok;
    tick(CPB);
    rx = 1'b1;
    tick(2 * CPB);
    if (!stop_ok)                  exp_ferr = 1'b1;
    else if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else                           exp_ovf = 1'b1;
  endtask

  task automatic checkOutput(input string name);
    checkVal({name, " count"}, count, exp_q.size());
    checkVal({name, " valid"}, valid, (exp_q.size() != 0) ? 1 : 0);
    checkVal({name, " rec_byte"}, rec_byte, (exp_q.size() != 0) ? exp_q[0] : 0);
    checkVal({name, " overflow"}, overflow, exp_ovf);
    checkVal({name, " frame_err"}, frame_err, exp_ferr);
`ifndef UART_RX_ECHO_EN
    checkVal({name, " tx"}, tx, 1);
`endif
  endtask

  task automatic popOne();
    pop = 1'b1;
    tick(1);
    pop = 1'b0;
  endtask

  task automatic clrErr();
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    exp_ovf  = 1'b0;
    exp_ferr = 1'b0;
  endtask

  task automatic drain();
    while (exp_q.size() > 0) popOne();
  endtask

`ifdef UART_RX_ECHO_EN
  task automatic captureEcho(input logic [7:0] b);
    int k;
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    k = 0;
    while (tx !== 1'b0 && k < 20 * CPB) begin
      tick(1);
      k++;
    end
    if (k >= 20 * CPB) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL echo_start: tx never fell, waited %0d cycles", k);
    end else begin
      tick(CPB / 2);
      for (int j = 0; j < 10; j++) begin
        checkVal($sformatf("echo_bit%0d", j), tx, frame[j]);
        tick(CPB);
      end
    end
  endtask
`endif

  // Scoreboard monitor: every accepted pop must present the oldest model byte.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (pop && rst_n) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          checkVal("pop_data", rec_byte, e);
          checkVal("pop_valid", valid, 1);
        end else begin
          checkVal("pop_on_empty_valid", valid, 0);
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    logic [7:0] b;
    n_cmp = 0;
    n_bad = 0;
    exp_ovf = 1'b0;
    exp_ferr = 1'b0;
    rst_n = 1'b0;
    rx = 1'b1;
    pop = 1'b0;
    clr_err = 1'b0;
    tick(3);
    checkOutput("reset");
    checkVal("reset tx", tx, 1);
    rst_n = 1'b1;
    tick(2);

`ifdef UART_RX_ECHO_EN
    fork
      applyStimulus(8'h55, 1'b1);
      captureEcho(8'h55);
    join
    tick(12 * CPB);
`else
    applyStimulus(8'h55, 1'b1);
`endif
    checkOutput("first_55");
    drain();

    applyStimulus(8'hA5, 1'b1);
    checkOutput("single_a5");
    popOne();
    checkOutput("single_popped");

    for (int i = 0; i < 17; i++) applyStimulus(8'(i), 1'b1);
    checkOutput("burst17");
    repeat (16) popOne();
    checkOutput("burst_drained");
    popOne();
    checkOutput("pop_empty");
    clrErr();
    checkOutput("ovf_cleared");

    applyStimulus(8'h3C, 1'b0);
    checkOutput("frame_err");
    clrErr();
    checkOutput("ferr_cleared");

    rx = 1'b0;
    tick(5);
    rx = 1'b1;
    tick(3 * CPB);
    checkOutput("glitch");
    applyStimulus(8'hC3, 1'b1);
    checkOutput("after_glitch");
    drain();

    for (int i = 0; i < DEPTH; i++) applyStimulus(8'($urandom_range(0, 255)), 1'b1);
    checkOutput("filled");
    fork
      applyStimulus(8'h77, 1'b1);
      begin
        k = 0;
        while (dut.rx_push !== 1'b1 && k < 12 * CPB) begin
          tick(1);
          k++;
        end
        if (k >= 12 * CPB) begin
          n_cmp++;
          n_bad++;
          $display("[TB] FAIL push_wait: no push seen within %0d cycles", k);
        end else begin
          popOne();
        end
      end
    join
    checkOutput("full_push_pop");
    drain();
    checkOutput("after_77");

    applyStimulus(8'h12, 1'b1);
    rx = 1'b0;
    tick(CPB);
    rx = 1'b1;
    tick(3 * CPB);
    rst_n = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0;
    exp_ferr = 1'b0;
    #2;
    checkOutput("reset_mid");
    checkVal("reset_mid tx", tx, 1);
    tick(2);
    rst_n = 1'b1;
    tick(8 * CPB);
    checkOutput("post_reset");
    checkVal("post_reset tx", tx, 1);
    applyStimulus(8'h5A, 1'b1);
    checkOutput("restart");

    for (int i = 0; i < 25; i++) begin
      b = 8'($urandom_range(0, 255));
      applyStimulus(b, $urandom_range(0, 7) != 0);
      repeat ($urandom_range(0, 2)) popOne();
      if ($urandom_range(0, 5) == 0) clrErr();
      checkOutput($sformatf("rand%0d", i));
    end
    drain();
    checkOutput("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
